mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/arb_pick2.sv | 36 +++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-requester memory arbiter.
//   state_t   : arbiter FSM states (IDLE / WAIT / DONE)
//   req_id_t  : requester identity (ID_LSU / ID_DMA)
//   CNT_W     : width of the memory-latency counter
package mem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        ID_LSU = 1'b0,
        ID_DMA = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-side bus of mem_arbiter.
// Signal names follow the arbiter's point of view (i_ = into arbiter).
//   LSU / DMA : req, we, addr, wdata, be in; gnt, rvalid, rdata out
//   memory    : req, we, addr, wdata, be out; rdata in
//   o_lsu_stall : hold request to the LSU MEM stage
// Modports: slave = arbiter side, master = requester/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                i_lsu_req;
    logic                i_lsu_we;
    logic [ADDR_W-1:0]   i_lsu_addr;
    logic [DATA_W-1:0]   i_lsu_wdata;
    logic [DATA_W/8-1:0] i_lsu_be;
    logic                i_dma_req;
    logic                i_dma_we;
    logic [ADDR_W-1:0]   i_dma_addr;
    logic [DATA_W-1:0]   i_dma_wdata;
    logic [DATA_W/8-1:0] i_dma_be;
    logic                o_lsu_gnt;
    logic                o_dma_gnt;
    logic                o_lsu_rvalid;
    logic                o_dma_rvalid;
    logic [DATA_W-1:0]   o_lsu_rdata;
    logic [DATA_W-1:0]   o_dma_rdata;
    logic                o_mem_req;
    logic                o_mem_we;
    logic [ADDR_W-1:0]   o_mem_addr;
    logic [DATA_W-1:0]   o_mem_wdata;
    logic [DATA_W/8-1:0] o_mem_be;
    logic [DATA_W-1:0]   i_mem_rdata;
    logic                o_lsu_stall;

    modport slave (
        input  i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_wdata, i_lsu_be,
        input  i_dma_req, i_dma_we, i_dma_addr, i_dma_wdata, i_dma_be,
        input  i_mem_rdata,
        output o_lsu_gnt, o_dma_gnt, o_lsu_rvalid, o_dma_rvalid,
        output o_lsu_rdata, o_dma_rdata,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        output o_lsu_stall
    );

    modport master (
        output i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_wdata, i_lsu_be,
        output i_dma_req, i_dma_we, i_dma_addr, i_dma_wdata, i_dma_be,
        output i_mem_rdata,
        input  o_lsu_gnt, o_dma_gnt, o_lsu_rvalid, o_dma_rvalid,
        input  o_lsu_rdata, o_dma_rdata,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        input  o_lsu_stall
    );
endinterface

// File: rtl/arb_pick2.sv
// arb_pick2: two-way grant selection.
//   i_req_lsu, i_req_dma : requests
//   i_last               : requester granted most recently
//   o_gnt                : one-hot grant, bit0 = LSU, bit1 = DMA
// Macro ARB_RR_EN: defined -> round-robin on conflict; undefined -> LSU priority.
module arb_pick2 import mem_arb_pkg::*; (
    input  logic       i_req_lsu,
    input  logic       i_req_dma,
    input  req_id_t    i_last,
    output logic [1:0] o_gnt
);
`ifdef ARB_RR_EN
    always_comb begin
        o_gnt = '0;
        if (i_req_lsu && i_req_dma) begin
            o_gnt = (i_last == ID_LSU) ? 2'b10 : 2'b01;
        end else if (i_req_lsu) begin
            o_gnt = 2'b01;
        end else if (i_req_dma) begin
            o_gnt = 2'b10;
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = i_last;

    always_comb begin
        o_gnt = '0;
        if (i_req_lsu) begin
            o_gnt = 2'b01;
        end else if (i_req_dma) begin
            o_gnt = 2'b10;
        end
    end
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an LSU and a DMA requester onto one single-port
// memory with fixed read latency MEM_LAT. One transaction at a time:
// gnt at T, memory strobe at T+1, completion pulse at T+MEM_LAT+2.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : mem_arbiter_if.slave (requester handshakes, memory command,
//             read data, LSU stall)
// Macro ARB_RR_EN: round-robin arbitration on simultaneous requests
// (undefined: LSU always wins).
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input logic          i_clk,
    input logic          i_reset,
    mem_arbiter_if.slave bus
);
    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_be;
    req_id_t             r_id;
    logic [DATA_W-1:0]   r_rdata;

    logic [1:0]          w_pick;
    logic                w_lsu_gnt;
    logic                w_dma_gnt;
    logic                w_mem_first;
    logic                w_lsu_rvalid;
    logic                w_dma_rvalid;
    req_id_t             w_last;

`ifdef ARB_RR_EN
    req_id_t             r_last;
    assign w_last = r_last;
`else
    assign w_last = ID_DMA;
`endif

    arb_pick2 u_pick (
        .i_req_lsu (bus.i_lsu_req),
        .i_req_dma (bus.i_dma_req),
        .i_last    (w_last),
        .o_gnt     (w_pick)
    );

    // Grants only in IDLE; reset suppresses them so nothing is accepted
    // in a cycle whose state update is about to be discarded.
    always_comb begin
        w_state_nxt = r_state;
        w_lsu_gnt   = 1'b0;
        w_dma_gnt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!i_reset && (w_pick != 2'b00)) begin
                    w_lsu_gnt   = w_pick[0];
                    w_dma_gnt   = w_pick[1];
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == CNT_W'(MEM_LAT)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_id    <= ID_LSU;
            r_rdata <= '0;
`ifdef ARB_RR_EN
            r_last  <= ID_DMA;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_lsu_gnt || w_dma_gnt) begin
                r_cnt   <= '0;
                r_we    <= w_dma_gnt ? bus.i_dma_we    : bus.i_lsu_we;
                r_addr  <= w_dma_gnt ? bus.i_dma_addr  : bus.i_lsu_addr;
                r_wdata <= w_dma_gnt ? bus.i_dma_wdata : bus.i_lsu_wdata;
                r_be    <= w_dma_gnt ? bus.i_dma_be    : bus.i_lsu_be;
                r_id    <= w_dma_gnt ? ID_DMA : ID_LSU;
`ifdef ARB_RR_EN
                r_last  <= w_dma_gnt ? ID_DMA : ID_LSU;
`endif
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == CNT_W'(MEM_LAT)) begin
                    r_rdata <= r_we ? '0 : bus.i_mem_rdata;
                end
            end
        end
    end

    // Memory strobe only in the first WAIT cycle (counter still zero).
    assign w_mem_first  = !i_reset && (r_state == WAIT) && (r_cnt == '0);
    assign w_lsu_rvalid = !i_reset && (r_state == DONE) && (r_id == ID_LSU);
    assign w_dma_rvalid = !i_reset && (r_state == DONE) && (r_id == ID_DMA);

    assign bus.o_lsu_gnt    = w_lsu_gnt;
    assign bus.o_dma_gnt    = w_dma_gnt;
    assign bus.o_mem_req    = w_mem_first;
    assign bus.o_mem_we     = w_mem_first & r_we;
    assign bus.o_mem_addr   = w_mem_first ? r_addr  : '0;
    assign bus.o_mem_wdata  = w_mem_first ? r_wdata : '0;
    assign bus.o_mem_be     = w_mem_first ? r_be    : '0;
    assign bus.o_lsu_rvalid = w_lsu_rvalid;
    assign bus.o_dma_rvalid = w_dma_rvalid;
    assign bus.o_lsu_rdata  = w_lsu_rvalid ? r_rdata : '0;
    assign bus.o_dma_rdata  = w_dma_rvalid ? r_rdata : '0;
    assign bus.o_lsu_stall  = bus.i_lsu_req & ~w_lsu_rvalid;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a completion scoreboard.
// Two instances: MEM_LAT=2 (main) and MEM_LAT=1 (latency boundary).
// Expectations for simultaneous requests follow ARB_RR_EN.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        logic        is_dma;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t q2[$];
    exp_t q1[$];
    logic [31:0] p2_s1, p2_s2, p1_s1;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b2 ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut2 (
        .i_clk(clk), .i_reset(rst), .bus(b2.slave));
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .i_clk(clk), .i_reset(rst), .bus(b1.slave));

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {~a[15:0], a[15:0]};
    endfunction

    // Memory models: return data only MEM_LAT cycles after a strobe.
    always @(posedge clk) begin
        p2_s1 <= b2.o_mem_req ? mem_f(b2.o_mem_addr) : 32'hBAD0BAD0;
        p2_s2 <= p2_s1;
        p1_s1 <= b1.o_mem_req ? mem_f(b1.o_mem_addr) : 32'hBAD1BAD1;
    end
    assign b2.i_mem_rdata = p2_s2;
    assign b1.i_mem_rdata = p1_s1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lsu2(input logic req, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        b2.i_lsu_req = req; b2.i_lsu_we = we; b2.i_lsu_addr = a;
        b2.i_lsu_wdata = d; b2.i_lsu_be = be;
    endtask

    task automatic dma2(input logic req, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        b2.i_dma_req = req; b2.i_dma_we = we; b2.i_dma_addr = a;
        b2.i_dma_wdata = d; b2.i_dma_be = be;
    endtask

    task automatic lsu1(input logic req, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        b1.i_lsu_req = req; b1.i_lsu_we = we; b1.i_lsu_addr = a;
        b1.i_lsu_wdata = d; b1.i_lsu_be = be;
    endtask

    function automatic logic any2();
        return |{b2.o_lsu_gnt, b2.o_dma_gnt, b2.o_lsu_rvalid, b2.o_dma_rvalid,
                 b2.o_lsu_rdata, b2.o_dma_rdata, b2.o_mem_req, b2.o_mem_we,
                 b2.o_mem_addr, b2.o_mem_wdata, b2.o_mem_be, b2.o_lsu_stall};
    endfunction

    function automatic logic any1();
        return |{b1.o_lsu_gnt, b1.o_dma_gnt, b1.o_lsu_rvalid, b1.o_dma_rvalid,
                 b1.o_lsu_rdata, b1.o_dma_rdata, b1.o_mem_req, b1.o_mem_we,
                 b1.o_mem_addr, b1.o_mem_wdata, b1.o_mem_be, b1.o_lsu_stall};
    endfunction

    // Scoreboards: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (b2.o_lsu_rvalid || b2.o_dma_rvalid) begin
            exp_t e;
            chk("sb2_expected", q2.size() != 0, 1);
            if (q2.size() != 0) begin
                e = q2.pop_front();
                chk("sb2_port", {b2.o_lsu_rvalid, b2.o_dma_rvalid}, e.is_dma ? 2'b01 : 2'b10);
                chk("sb2_data", e.is_dma ? b2.o_dma_rdata : b2.o_lsu_rdata, e.data);
                chk("sb2_other", e.is_dma ? b2.o_lsu_rdata : b2.o_dma_rdata, 0);
            end
        end
        if (b1.o_lsu_rvalid || b1.o_dma_rvalid) begin
            exp_t e;
            chk("sb1_expected", q1.size() != 0, 1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("sb1_port", {b1.o_lsu_rvalid, b1.o_dma_rvalid}, e.is_dma ? 2'b01 : 2'b10);
                chk("sb1_data", e.is_dma ? b1.o_dma_rdata : b1.o_lsu_rdata, e.data);
            end
        end
    end

    initial begin
        logic exp_dma;
        rst = 1'b1;
        lsu2(0, 0, 0, 0, 0); dma2(0, 0, 0, 0, 0);
        lsu1(0, 0, 0, 0, 0);
        b1.i_dma_req = 0; b1.i_dma_we = 0; b1.i_dma_addr = 0;
        b1.i_dma_wdata = 0; b1.i_dma_be = 0;
        cyc(); cyc();
        chk("rst_hold_outs", any2(), 0);
        cyc(); rst = 1'b0; #1;
        chk("rst_outs2", any2(), 0);
        chk("rst_outs1", any1(), 0);

        // LSU read at 0x100
        cyc(); lsu2(1, 0, 32'h100, 0, 4'hF); q2.push_back('{1'b0, 32'hDEADBEEF}); #1;
        chk("t1_gnt", {b2.o_lsu_gnt, b2.o_dma_gnt}, 2'b10);
        chk("t1_stall_T", b2.o_lsu_stall, 1);
        chk("t1_memreq_T", b2.o_mem_req, 0);
        cyc(); #1;
        chk("t1_memreq", b2.o_mem_req, 1);
        chk("t1_addr", b2.o_mem_addr, 32'h100);
        chk("t1_we", b2.o_mem_we, 0);
        chk("t1_nognt", {b2.o_lsu_gnt, b2.o_dma_gnt}, 0);
        chk("t1_stall_T1", b2.o_lsu_stall, 1);
        cyc(); #1;
        chk("t1_memreq_T2", b2.o_mem_req, 0);
        chk("t1_addr_T2", b2.o_mem_addr, 0);
        chk("t1_stall_T2", b2.o_lsu_stall, 1);
        cyc(); #1;
        chk("t1_stall_T3", b2.o_lsu_stall, 1);
        chk("t1_rvalid_T3", b2.o_lsu_rvalid, 0);
        cyc(); #1;
        chk("t1_rvalid_T4", b2.o_lsu_rvalid, 1);
        chk("t1_rdata_T4", b2.o_lsu_rdata, 32'hDEADBEEF);
        chk("t1_stall_T4", b2.o_lsu_stall, 0);
        cyc(); lsu2(0, 0, 0, 0, 0); #1;
        chk("t1_idle", any2(), 0);

        // DMA write; fields scrambled after gnt to prove sampling at gnt
        cyc(); dma2(1, 1, 32'h200, 32'h12345678, 4'hF); q2.push_back('{1'b1, 32'h0}); #1;
        chk("t2_gnt", {b2.o_lsu_gnt, b2.o_dma_gnt}, 2'b01);
        cyc(); dma2(0, 0, 32'hFFFFFFFC, 32'hCAFE, 4'h3); #1;
        chk("t2_memreq", b2.o_mem_req, 1);
        chk("t2_we", b2.o_mem_we, 1);
        chk("t2_addr", b2.o_mem_addr, 32'h200);
        chk("t2_wdata", b2.o_mem_wdata, 32'h12345678);
        chk("t2_be", b2.o_mem_be, 4'hF);
        chk("t2_lsu_quiet", |{b2.o_lsu_gnt, b2.o_lsu_rvalid, b2.o_lsu_rdata, b2.o_lsu_stall}, 0);
        cyc(); #1;
        chk("t2_cmd_clear", |{b2.o_mem_req, b2.o_mem_we, b2.o_mem_wdata, b2.o_mem_be}, 0);
        cyc(); #1;
        chk("t2_rvalid_T3", b2.o_dma_rvalid, 0);
        cyc(); #1;
        chk("t2_rvalid_T4", b2.o_dma_rvalid, 1);
        chk("t2_rdata_T4", b2.o_dma_rdata, 0);
        chk("t2_lsu_rvalid", b2.o_lsu_rvalid, 0);
        cyc(); #1;
        chk("t2_idle", any2(), 0);

        // DMA request arriving mid-transaction waits for IDLE
        cyc(); lsu2(1, 0, 32'h40, 0, 4'hF); q2.push_back('{1'b0, mem_f(32'h40)}); #1;
        chk("t3_lsu_gnt", b2.o_lsu_gnt, 1);
        cyc(); lsu2(0, 0, 0, 0, 0); dma2(1, 0, 32'h80, 0, 4'hF); #1;
        chk("t3_dma_wait1", b2.o_dma_gnt, 0);
        for (int k = 2; k <= 4; k++) begin
            cyc(); #1;
            chk("t3_dma_wait", b2.o_dma_gnt, 0);
        end
        chk("t3_lsu_done", b2.o_lsu_rvalid, 1);
        cyc(); q2.push_back('{1'b1, mem_f(32'h80)}); #1;
        chk("t3_dma_gnt_T5", {b2.o_lsu_gnt, b2.o_dma_gnt}, 2'b01);
        cyc(); dma2(0, 0, 0, 0, 0); #1;
        chk("t3_dma_addr", b2.o_mem_addr, 32'h80);
        cyc(); cyc(); cyc(); #1;
        chk("t3_dma_rvalid", b2.o_dma_rvalid, 1);
        cyc(); #1;
        chk("t3_idle", any2(), 0);

        // Both requesters held continuously for three transactions
        for (int k = 0; k < 15; k++) begin
            cyc();
            if (k == 0) begin
                lsu2(1, 0, 32'h300, 0, 4'hF);
                dma2(1, 0, 32'h400, 0, 4'hF);
            end
            #1;
            if (k % 5 == 0) begin
`ifdef ARB_RR_EN
                exp_dma = (k == 5);
`else
                exp_dma = 1'b0;
`endif
                chk("t4_gnt", {b2.o_lsu_gnt, b2.o_dma_gnt}, exp_dma ? 2'b01 : 2'b10);
                q2.push_back('{exp_dma, exp_dma ? mem_f(32'h400) : mem_f(32'h300)});
            end else begin
                chk("t4_nognt", {b2.o_lsu_gnt, b2.o_dma_gnt}, 2'b00);
            end
        end
        cyc(); lsu2(0, 0, 0, 0, 0); dma2(0, 0, 0, 0, 0); #1;
        chk("t4_idle", any2(), 0);

        // Reset during WAIT discards the read
        cyc(); lsu2(1, 0, 32'h600, 0, 4'hF); #1;
        chk("t5_gnt", b2.o_lsu_gnt, 1);
        cyc(); #1;
        chk("t5_memreq", b2.o_mem_req, 1);
        cyc(); rst = 1'b1; lsu2(0, 0, 0, 0, 0); #1;
        chk("t5_in_reset", any2(), 0);
        cyc(); rst = 1'b0; lsu2(1, 0, 32'h500, 0, 4'hF); q2.push_back('{1'b0, mem_f(32'h500)}); #1;
        chk("t5_regnt", b2.o_lsu_gnt, 1);
        chk("t5_memreq_off", b2.o_mem_req, 0);
        chk("t5_no_rvalid", b2.o_lsu_rvalid, 0);
        cyc(); lsu2(0, 0, 0, 0, 0); #1;
        chk("t5_addr", b2.o_mem_addr, 32'h500);
        cyc(); cyc(); cyc(); #1;
        chk("t5_rvalid", b2.o_lsu_rvalid, 1);
        cyc(); #1;
        chk("t5_idle", any2(), 0);

        // MEM_LAT=1 boundary
        cyc(); lsu1(1, 0, 32'h100, 0, 4'hF); q1.push_back('{1'b0, 32'hDEADBEEF}); #1;
        chk("t6_gnt", b1.o_lsu_gnt, 1);
        cyc(); #1;
        chk("t6_memreq", b1.o_mem_req, 1);
        chk("t6_addr", b1.o_mem_addr, 32'h100);
        cyc(); #1;
        chk("t6_rvalid_T2", b1.o_lsu_rvalid, 0);
        cyc(); #1;
        chk("t6_rvalid_T3", b1.o_lsu_rvalid, 1);
        chk("t6_rdata_T3", b1.o_lsu_rdata, 32'hDEADBEEF);
        chk("t6_nognt_T3", b1.o_lsu_gnt, 0);
        cyc(); lsu1(1, 0, 32'h104, 0, 4'hF); q1.push_back('{1'b0, mem_f(32'h104)}); #1;
        chk("t6_gnt_T4", b1.o_lsu_gnt, 1);
        cyc(); lsu1(0, 0, 0, 0, 0); #1;
        chk("t6_addr2", b1.o_mem_addr, 32'h104);
        cyc(); cyc(); #1;
        chk("t6_rvalid2", b1.o_lsu_rvalid, 1);
        cyc(); #1;
        chk("t6_idle", any1(), 0);

        cyc(); cyc(); cyc();
        chk("sb2_drained", q2.size(), 0);
        chk("sb1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
